gray_counter: RTL
=================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 en  input  1  count enable; one step per cycle while high.
REQ-005 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_bin  input  WIDTH  binary value to load when load=1.
REQ-008 binary  output  WIDTH  registered binary count.
REQ-009 gray  output  WIDTH  registered Gray encoding of binary.
REQ-010 wrap  output  1  one-cycle registered pulse on count wrap-around.
REQ-011 gray_err  output  1  sticky Gray-step error flag; present only per REQ-027.

Function
REQ-012 Next-state priority SHALL be: load, then en, then hold.
REQ-013 load=1: binary <= load_bin and gray <= load_bin ^ (load_bin >> 1) at the next edge, regardless of en and up_dn.
REQ-014 en=1, load=0, up_dn=1: binary <= binary + 1, modulo 2^WIDTH.
REQ-015 en=1, load=0, up_dn=0: binary <= binary - 1, modulo 2^WIDTH.
REQ-016 en=0, load=0: binary, gray hold.
REQ-017 gray SHALL be computed from the next binary value and registered on the same edge as binary, so gray == binary ^ (binary >> 1) holds in every cycle; there is no added latency between them.
REQ-018 Latency: one cycle from sampled inputs to updated binary and gray.
REQ-019 Up-count wrap: binary = 2^WIDTH-1 with en=1, up_dn=1, load=0 SHALL give binary = 0, gray = 0, and wrap = 1 for exactly the following cycle.
REQ-020 Down-count wrap: binary = 0 with en=1, up_dn=0, load=0 SHALL give binary = 2^WIDTH-1, gray = 1 followed by WIDTH-1 zeros, and wrap = 1 for exactly the following cycle.
REQ-021 wrap SHALL be 0 in every other cycle, including after any load, even when a load goes from max to 0.
REQ-022 If up_dn changes while en=1, the step direction SHALL follow the value sampled at that edge; there is no turnaround penalty.
REQ-023 While counting (no load), consecutive gray values SHALL differ in exactly one bit.

Reset
REQ-024 rst_n=0 SHALL immediately force binary = 0, gray = 0, wrap = 0 and gray_err = 0, without waiting for a clock edge.
REQ-025 On rst_n deassertion, counting resumes from 0 at the first posedge with en=1; a load or count in progress when reset asserts is discarded.

Configuration
REQ-026 Macro GRAY_COUNTER_CHECK_EN selects the self-check logic.
REQ-027 With GRAY_COUNTER_CHECK_EN defined:
- the block keeps a registered copy of the previous gray;
- in any cycle following a count step (not a load or hold), if gray differs from the previous gray in a number of bits other than one, gray_err SHALL set;
- gray_err stays set until reset.
REQ-028 Without GRAY_COUNTER_CHECK_EN:
- the check logic and the gray_err port SHALL be absent;
- all other behaviour is identical.

Verification (WIDTH=4)
REQ-029 Reset, then en=1, up_dn=1 for 16 cycles -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000; wrap=1 on the 0000 cycle only.
REQ-030 load=1, load_bin=0101 -> next cycle binary=0101, gray=0111, wrap=0; then en=1, up_dn=0 for 2 cycles -> gray 0110, 0010.
REQ-031 binary=0000, en=1, up_dn=0 -> binary=1111, gray=1000, wrap=1 for one cycle.
REQ-032 load=1 and en=1 in the same cycle, load_bin=1010 -> binary=1010, gray=1111; the enable step is ignored.
REQ-033 rst_n pulsed low mid-count at binary=0110, asynchronous to clk -> binary, gray and wrap are 0 before the next edge.
REQ-034 With GRAY_COUNTER_CHECK_EN: 40 cycles of random en and up_dn with no loads -> gray_err stays 0, and gray == binary ^ (binary >> 1) every cycle.

Source files
------------

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered Gray output and wrap pulse
// Define GRAY_COUNTER_CHECK_EN to add the sticky single-bit-step checker and its gray_err port.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
`ifdef GRAY_COUNTER_CHECK_EN
    output logic             gray_err,
`endif
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             step;

    assign step = en && !load;

    always_comb begin
        binary_d = binary_q;
        wrap_d   = 1'b0;
        if (load) begin
            binary_d = load_bin;
        end else if (en) begin
            if (up_dn) begin
                binary_d = binary_q + ONE_VAL;
                wrap_d   = (binary_q == MAX_VAL);
            end else begin
                binary_d = binary_q - ONE_VAL;
                wrap_d   = (binary_q == '0);
            end
        end
        // Encode from the next binary so both registers update on the same edge.
        gray_d = binary_d ^ (binary_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_q <= '0;
            gray_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            wrap_q   <= wrap_d;
        end
    end

    assign binary = binary_q;
    assign gray   = gray_q;
    assign wrap   = wrap_q;

`ifdef GRAY_COUNTER_CHECK_EN
    logic [WIDTH-1:0] prev_gray_q;
    logic             stepped_q;
    logic             gray_err_q;
    logic [WIDTH-1:0] diff;
    logic [4:0]       ones;

    always_comb begin
        diff = gray_q ^ prev_gray_q;
        ones = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {4'b0000, diff[i]};
        end
    end

    // stepped_q marks that the current gray_q came from a count step, not a load or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q <= '0;
            stepped_q   <= 1'b0;
            gray_err_q  <= 1'b0;
        end else begin
            prev_gray_q <= gray_q;
            stepped_q   <= step;
            if (stepped_q && ones != 5'd1) begin
                gray_err_q <= 1'b1;
            end
        end
    end

    assign gray_err = gray_err_q;
`else
    logic unused_step;
    assign unused_step = step;
`endif

endmodule
